uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_ctrl_pkg.sv | 13 +
 rtl/uart_rr_pick.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared types and sizing for the UART transmit arbiter.
package uart_ctrl_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned TMO_W      = 20;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin picker: first set req bit at or after ptr, wrapping modulo NUM_REQ.
module uart_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  int unsigned cand;

  // Scan from ptr upward; the first hit wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = (32'(ptr) + off) % NUM_REQ;
      if (!valid && (|(req & (NUM_REQ'(1) << cand)))) begin
        valid = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned       NUM_REQ = 4,
  parameter int unsigned       DATA_W  = DATA_W_DEF,
  parameter logic [TMO_W-1:0]  TMO_CYC = 20'hFFFFF,
  localparam int unsigned      IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         done,
  output logic                       err,
  output logic                       tx_start,
  output logic [DATA_W-1:0]          tx_data,
  input  logic                       tx_busy,
  input  logic                       tx_done,
  output logic [IDX_W-1:0]           owner,
  output logic                       active
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d, tmo_inc;
  logic [IDX_W-1:0]   owner_d;
  logic [DATA_W-1:0]  tx_data_d;
  logic [NUM_REQ-1:0] gnt_d, done_d;
  logic               err_d, tx_start_d, active_d;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   ptr_after_owner;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req   (req),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Next-state and registered-output values; tmo counts cycles since tx_start.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    tmo_d      = tmo_q;
    owner_d    = owner;
    tx_data_d  = tx_data;
    gnt_d      = '0;
    done_d     = '0;
    err_d      = 1'b0;
    tx_start_d = 1'b0;

    tmo_inc         = (tmo_q == '1) ? tmo_q : tmo_q + TMO_W'(1);
    ptr_after_owner = ((32'(owner) + 32'd1) >= NUM_REQ) ? '0 : owner + IDX_W'(1);

    case (state_q)
      IDLE: begin
        if (pick_valid && !tx_busy) begin
          state_d    = START;
          owner_d    = pick_idx;
          tx_data_d  = DATA_W'(req_data >> (DATA_W * 32'(pick_idx)));
          gnt_d      = NUM_REQ'(1) << pick_idx;
          tx_start_d = 1'b1;
          tmo_d      = '0;
        end
      end
      START: begin
        // tx_done here belongs to nobody we launched; ignore it.
        state_d = WAIT_DONE;
        tmo_d   = tmo_inc;
      end
      WAIT_DONE: begin
        tmo_d = tmo_inc;
        if (tx_done) begin
          done_d   = NUM_REQ'(1) << owner;
          rr_ptr_d = ptr_after_owner;
          state_d  = IDLE;
        end else if (tmo_inc >= TMO_CYC) begin
          err_d    = 1'b1;
          rr_ptr_d = ptr_after_owner;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    active_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      tmo_q    <= '0;
      owner    <= '0;
      tx_data  <= '0;
      gnt      <= '0;
      done     <= '0;
      err      <= 1'b0;
      tx_start <= 1'b0;
      active   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      tmo_q    <= tmo_d;
      owner    <= owner_d;
      tx_data  <= tx_data_d;
      gnt      <= gnt_d;
      done     <= done_d;
      err      <= err_d;
      tx_start <= tx_start_d;
      active   <= active_d;
    end
  end

endmodule
